// File: rtl/quickq_pkg.sv
// Shared QuickQ definitions: default entry geometry, swap-engine state encoding,
// and the key-field extractor used by the queue datapaths.
package quickq_pkg;

    localparam int unsigned KEY_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_P,
        RD_C,
        CAP_C,
        CMP,
        WR_P,
        WR_C,
        DONE
    } swap_state_t;

    function automatic logic [KEY_W-1:0] key_of(input logic [DATA_W-1:0] entry);
        return entry[DATA_W-1 -: KEY_W];
    endfunction

endpackage

// File: rtl/quick_key_cmp.sv
// Heap-order key comparator: flags a swap when the child key beats the parent key.
// Equal keys never swap; keys are unsigned.
module quick_key_cmp #(
    parameter int unsigned KEY_W    = 16,
    parameter int unsigned MAX_HEAP = 0
) (
    input  logic [KEY_W-1:0] parent_key_i,
    input  logic [KEY_W-1:0] child_key_i,
    output logic             swap_o
);
    import quickq_pkg::*;

    always_comb begin
        swap_o = 1'b0;
        if (MAX_HEAP != 0) begin
            swap_o = child_key_i > parent_key_i;
        end else begin
            swap_o = child_key_i < parent_key_i;
        end
    end

endmodule

// File: rtl/quick_swap_unit.sv
// QuickQ compare-and-swap engine: reads a parent/child entry pair from BRAM,
// compares keys and writes them back exchanged when heap order is violated.
module quick_swap_unit #(
    parameter int unsigned KEY_W    = quickq_pkg::KEY_W,
    parameter int unsigned DATA_W   = quickq_pkg::DATA_W,
    parameter int unsigned ADDR_W   = quickq_pkg::ADDR_W,
    parameter int unsigned MAX_HEAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] parent_addr,
    input  logic [ADDR_W-1:0] child_addr,
    output logic              bram_re,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [DATA_W-1:0] bram_wr_data,
    output logic              busy,
    output logic              cmp_valid,
    output logic              result,
    output logic              swap_done
);
    import quickq_pkg::*;

    swap_state_t       state_q;
    logic [ADDR_W-1:0] paddr_q, caddr_q;
    logic [DATA_W-1:0] pdata_q, cdata_q;
    logic              re_q, we_q, busy_q, cmp_valid_q, result_q, swap_done_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              swap;

    // Child key taken straight off the read bus so result is registered on entry to CMP.
    quick_key_cmp #(
        .KEY_W    (KEY_W),
        .MAX_HEAP (MAX_HEAP)
    ) u_key_cmp (
        .parent_key_i (pdata_q[DATA_W-1 -: KEY_W]),
        .child_key_i  (bram_rd_data[DATA_W-1 -: KEY_W]),
        .swap_o       (swap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            caddr_q     <= '0;
            pdata_q     <= '0;
            cdata_q     <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            result_q    <= 1'b0;
            swap_done_q <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            cmp_valid_q <= 1'b0;
            swap_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        paddr_q   <= parent_addr;
                        caddr_q   <= child_addr;
                        re_q      <= 1'b1;
                        rd_addr_q <= parent_addr;
                        busy_q    <= 1'b1;
                        state_q   <= RD_P;
                    end
                end
                RD_P: begin
                    rd_addr_q <= caddr_q;
                    state_q   <= RD_C;
                end
                RD_C: begin
                    pdata_q <= bram_rd_data;
                    re_q    <= 1'b0;
                    state_q <= CAP_C;
                end
                CAP_C: begin
                    cdata_q     <= bram_rd_data;
                    result_q    <= swap;
                    cmp_valid_q <= 1'b1;
                    state_q     <= CMP;
                end
                CMP: begin
                    if (result_q) begin
                        we_q      <= 1'b1;
                        wr_addr_q <= paddr_q;
                        wr_data_q <= cdata_q;
                        state_q   <= WR_P;
                    end else begin
                        swap_done_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                WR_P: begin
                    wr_addr_q <= caddr_q;
                    wr_data_q <= pdata_q;
                    state_q   <= WR_C;
                end
                WR_C: begin
                    we_q        <= 1'b0;
                    swap_done_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bram_re      = re_q;
    assign bram_rd_addr = rd_addr_q;
    assign bram_we      = we_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign cmp_valid    = cmp_valid_q;
    assign result       = result_q;
    assign swap_done    = swap_done_q;

endmodule

// File: doc/quick_swap_unit.md
# quick_swap_unit

Compare-and-swap engine for the QuickQ hardware priority queue, directly downstream of the control FSM. On a start pulse from the control FSM it reads a parent and a child entry from the queue BRAM and compares their keys. When heap order is violated it writes the two entries back exchanged. It then returns `result` (swap performed) and `swap_done` to the FSM.

## Interface
- `KEY_W`, 16, key width in bits; the key is the MSB field of an entry: `entry[DATA_W-1 -: KEY_W]`.
- `DATA_W`, 32, full entry width (key plus payload); must be >= `KEY_W`.
- `ADDR_W`, 32, BRAM address width.
- `MAX_HEAP`, 0, 0 = min-heap, 1 = max-heap.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request pulse from the control FSM.
- `parent_addr`  in  ADDR_W  parent entry address, sampled on start.
- `child_addr`  in  ADDR_W  child entry address, sampled on start.
- `bram_re`  out  1  BRAM read enable.
- `bram_rd_addr`  out  ADDR_W  BRAM read address.
- `bram_rd_data`  in  DATA_W  BRAM read data, valid one cycle after `bram_re`.
- `bram_we`  out  1  BRAM write enable.
- `bram_wr_addr`  out  ADDR_W  BRAM write address.
- `bram_wr_data`  out  DATA_W  BRAM write data.
- `busy`  out  1  high in every state except IDLE.
- `cmp_valid`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  1  1 = swap required and performed; held until the next compare.
- `swap_done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, RD_P, RD_C, CAP_C, CMP, WR_P, WR_C and DONE.
- **IDLE:** on `start`, latch both addresses and go to RD_P. `start` is ignored in every other state; it is neither queued nor an error.
- **RD_P:** `bram_re=1`, `bram_rd_addr=parent_q`. Next state RD_C.
- **RD_C:** `bram_re=1`, `bram_rd_addr=child_q`. Capture `parent_d <= bram_rd_data`. Next state CAP_C.
- **CAP_C:** capture `child_d <= bram_rd_data`. Next state CMP.
- **CMP:** keys are compared unsigned.
  - Min-heap: `swap = child_key < parent_key`.
  - Max-heap: `swap = child_key > parent_key`.
  - Equal keys never swap.
  - Register `result <= swap` and pulse `cmp_valid`.
  - Next state is WR_P if `swap`, otherwise DONE.
- **WR_P:** `bram_we=1`, `bram_wr_addr=parent_q`, `bram_wr_data=child_d`. Next state WR_C.
- **WR_C:** `bram_we=1`, `bram_wr_addr=child_q`, `bram_wr_data=parent_d`. Next state DONE.
- **DONE:** pulse `swap_done`. Next state IDLE.
- The whole entry, payload included, is swapped.
- `bram_re` and `bram_we` are never high in the same cycle.
- If `parent_addr == child_addr`, the keys compare equal, so no swap occurs and no write is issued.

## Timing
- Reset values:
  - State is IDLE.
  - `bram_re`, `bram_we`, `busy`, `cmp_valid`, `result` and `swap_done` are all 0.
  - All address and data outputs and internal registers are 0.
- All outputs are decoded from registered state; there are no combinational paths from input to output.
- With `start` sampled at edge T:
  - `cmp_valid` is high in cycle T+4.
  - No-swap: `swap_done` is high in cycle T+5.
  - Swap: writes occur in cycles T+5 and T+6, and `swap_done` is high in cycle T+7.
- `busy` is high from cycle T+1 through the `swap_done` cycle inclusive.
- A new `start` is accepted in the cycle immediately after `swap_done`.
- `result` holds its value after DONE until the next CMP.
- Reset mid-operation:
  - The unit returns to IDLE immediately with all outputs 0.
  - A write already in progress is not completed. Reset between WR_P and WR_C can leave a duplicated entry; the control FSM must reissue the operation after reset.

## Structure
- `quickq_pkg` holds:
  - the `swap_state_t` enum;
  - the `KEY_W`, `DATA_W` and `ADDR_W` defaults shared with the control FSM and BRAM wrapper;
  - a `key_of()` function that extracts the key field.
- One sub-module, `quick_key_cmp`: purely combinational, parameterised by `KEY_W` and `MAX_HEAP`, produces `swap`. Reused by the dequeue sift logic.
- The FSM and datapath registers live in a single module.

## Test plan
- **Min-heap swap:** parent@3 = 0x0050_AAAA, child@7 = 0x0010_BBBB, pulse `start`.
  - `cmp_valid` at T+4 with `result=1`.
  - Writes at T+5 (addr 3 ← 0x0010_BBBB) and T+6 (addr 7 ← 0x0050_AAAA).
  - `swap_done` at T+7.
- **No swap:** parent key 0x0010, child key 0x0050.
  - `result=0`, no `bram_we`, `swap_done` at T+5.
- **Equal keys and same address:** equal keys 0x0020, and separately `parent_addr == child_addr`.
  - `result=0` and no writes in both cases.
- **MAX_HEAP=1:** rerun the first scenario's data.
  - `result=0`, no writes.
- **Start while busy and back-to-back:** pulse `start` at T+2 with different addresses.
  - The T+2 pulse is ignored.
  - A second `start` in the cycle after `swap_done` is accepted, with its `cmp_valid` four cycles later.
- **Reset mid-operation:** assert `rst` low during WR_P.
  - All outputs are 0 immediately.
  - No write to the child address occurs.
  - A new `start` after reset release completes normally.
